up_counter_ctrl: RTL and testbench

- Parameterised up counter with a run-control FSM: start/stop, synchronous clear, parallel load, modulo limit and one-shot or free-run mode.
- Counts upward toward a limit. It is the counterpart to the team's free-running 4-bit down counter.
- Sits in the timing/sequencing logic. It provides an event count, a terminal-count pulse and busy/done status to downstream control.

---
 rtl/up_counter_ctrl.sv | 160 ++++++++++++++++
 tb/tb_up_counter_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/up_counter_ctrl.sv
// rtl/up_counter_ctrl.sv - run-controlled modulo up counter with terminal-count pulse
//
// Purpose:
//   Up counter with an IDLE/COUNT/DONE run-control FSM. It supports
//   start/stop, synchronous clear, parallel load (clamped to LIMIT) and a
//   modulo limit. The one_shot input selects between halting at LIMIT and
//   wrapping back to 0.
//
//   Optional macro UP_CNT_PRESCALE_EN: when defined, en cycles in COUNT are
//   divided by PRESCALE before they advance the count.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   (re)start counting from 0
//   stop      in   halt counting in COUNT, hold value
//   clr       in   synchronous clear to 0, return to IDLE
//   en        in   count enable
//   one_shot  in   1: halt at LIMIT; 0: wrap to 0
//   load      in   synchronous parallel load
//   load_val  in   load value, clamped to LIMIT
//   out       out  registered count
//   tc        out  one-cycle terminal-count pulse
//   busy      out  high in COUNT
//   done      out  high in DONE

module up_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int LIMIT    = 15,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             en,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             pre_clr;
    logic             pre_adv;

`ifdef UP_CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (pre_clr) begin
            pre_d = '0;
        end else if (pre_adv) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end
`else
    // Without the prescaler every qualified en cycle is a tick; a PRESCALE
    // below 1 is not a legal configuration and simply never ticks.
    assign tick = en && (PRESCALE >= 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        pre_clr = 1'b0;
        pre_adv = 1'b0;

        if (clr) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            pre_clr = 1'b1;
        end else if (load) begin
            cnt_d   = (load_val > LIMIT_W) ? LIMIT_W : load_val;
            pre_clr = 1'b1;
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end else if (start) begin
            // Restart behaves the same from every state.
            cnt_d   = '0;
            state_d = S_COUNT;
            pre_clr = 1'b1;
        end else if (state_q == S_COUNT) begin
            if (stop) begin
                state_d = S_IDLE;
                pre_clr = 1'b1;
            end else if (en) begin
                pre_adv = 1'b1;
                if (tick) begin
                    if (cnt_q < LIMIT_W) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        if (one_shot) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end
            end
        end

        busy_d = (state_d == S_COUNT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UP_CNT_PRESCALE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UP_CNT_PRESCALE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    assign out  = cnt_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb/tb_up_counter_ctrl.sv - randomized self-checking bench for up_counter_ctrl

module tb_up_counter_ctrl;

`ifdef UP_CNT_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    localparam int ST_IDLE  = 0;
    localparam int ST_COUNT = 1;
    localparam int ST_DONE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clr, en, one_shot, load;
    logic [3:0] load_val;
    logic [3:0] out15, out9;
    logic       tc15, tc9, busy15, busy9, done15, done9;

    always #5 clk = ~clk;

    up_counter_ctrl #(.WIDTH(4), .LIMIT(15), .PRESCALE(4)) u_dut15 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .en(en),
        .one_shot(one_shot), .load(load), .load_val(load_val),
        .out(out15), .tc(tc15), .busy(busy15), .done(done15)
    );

    up_counter_ctrl #(.WIDTH(4), .LIMIT(9), .PRESCALE(4)) u_dut9 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .en(en),
        .one_shot(one_shot), .load(load), .load_val(load_val),
        .out(out9), .tc(tc9), .busy(busy9), .done(done9)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = LIMIT 15, index 1 = LIMIT 9
    int lim   [2] = '{15, 9};
    int m_out [2];
    int m_st  [2];
    int m_tc  [2];
    int m_pre [2];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_st[k]  = ST_IDLE;
            m_tc[k]  = 0;
            m_pre[k] = 0;
        end
    endtask

    // One rising edge of the behavioural rules, applied in priority order.
    task automatic model_step(input int k);
        m_tc[k] = 0;
        if (clr) begin
            m_out[k] = 0;
            m_st[k]  = ST_IDLE;
            m_pre[k] = 0;
        end else if (load) begin
            m_out[k] = (int'(load_val) < lim[k]) ? int'(load_val) : lim[k];
            m_pre[k] = 0;
            if (m_st[k] == ST_DONE) m_st[k] = ST_IDLE;
        end else if (start) begin
            m_out[k] = 0;
            m_st[k]  = ST_COUNT;
            m_pre[k] = 0;
        end else if (m_st[k] == ST_COUNT && stop) begin
            m_st[k]  = ST_IDLE;
            m_pre[k] = 0;
        end else if (m_st[k] == ST_COUNT && en) begin
            if (m_pre[k] < P - 1) begin
                m_pre[k]++;
            end else begin
                m_pre[k] = 0;
                if (m_out[k] < lim[k]) begin
                    m_out[k]++;
                end else begin
                    m_tc[k] = 1;
                    if (one_shot) m_st[k] = ST_DONE;
                    else          m_out[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("out15",  int'(out15),  m_out[0]);
        check_eq("tc15",   int'(tc15),   m_tc[0]);
        check_eq("busy15", int'(busy15), int'(m_st[0] == ST_COUNT));
        check_eq("done15", int'(done15), int'(m_st[0] == ST_DONE));
        check_eq("out9",   int'(out9),   m_out[1]);
        check_eq("tc9",    int'(tc9),    m_tc[1]);
        check_eq("busy9",  int'(busy9),  int'(m_st[1] == ST_COUNT));
        check_eq("done9",  int'(done9),  int'(m_st[1] == ST_DONE));
    endtask

    // Inputs change just after the falling edge; outputs are checked there.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clr = 0; load = 0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        en = 0; one_shot = 0; load_val = 4'd0;
        model_reset();
        #2 compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // No start: counter stays at 0 regardless of en
        en = 1;
        for (int i = 0; i < 10; i++) cycle();
        check_eq("idle_hold_out15", int'(out15), 0);

        // Count to 7 then reset asynchronously mid-cycle
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 7 * P; i++) cycle();
        check_eq("pre_rst_out15", int'(out15), 7);
        async_reset();
        check_eq("post_rst_out15", int'(out15), 0);
        check_eq("post_rst_busy15", int'(busy15), 0);

        // Free-run wrap on both counters
        one_shot = 0; en = 1;
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 20 * P; i++) cycle();

        // One-shot: LIMIT 9 instance finishes and holds
        one_shot = 1;
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 12 * P; i++) cycle();
        check_eq("oneshot_out9", int'(out9), 9);
        check_eq("oneshot_done9", int'(done9), 1);
        start = 1; cycle(); start = 0;
        check_eq("restart_out9", int'(out9), 0);
        check_eq("restart_busy9", int'(busy9), 1);

        // Priority: clr beats load and start at out=5
        one_shot = 0;
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 5 * P; i++) cycle();
        check_eq("prio_pre_out9", int'(out9), 5);
        clr = 1; load = 1; start = 1; load_val = 4'd3; cycle(); idle_inputs();
        check_eq("prio_out9", int'(out9), 0);
        check_eq("prio_busy9", int'(busy9), 0);
        load = 1; load_val = 4'd12; cycle(); load = 0;
        check_eq("clamp_out9", int'(out9), 9);
        check_eq("noclamp_out15", int'(out15), 12);

        // Stop / en gating
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 4 * P; i++) cycle();
        en = 0;
        for (int i = 0; i < 3; i++) cycle();
        check_eq("engate_out9", int'(out9), 4);
        stop = 1; cycle(); stop = 0;
        en = 1;
        for (int i = 0; i < 3; i++) cycle();
        check_eq("stop_out9", int'(out9), 4);
        check_eq("stop_busy9", int'(busy9), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom % 60) == 0;
            load     = ($urandom % 25) == 0;
            start    = ($urandom % 20) == 0;
            stop     = ($urandom % 30) == 0;
            en       = ($urandom % 5) != 0;
            load_val = 4'($urandom);
            if (($urandom % 40) == 0) one_shot = ~one_shot;
            if (($urandom % 400) == 0) async_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
